note_key_encoder: RTL and testbench
===================================

Name: note_key_encoder

Overview:
- Converts the nine front-panel note buttons into the 4-bit noteKey code consumed by the seven-segment note display decoder and the tone generator.
- Synchronises and debounces the raw buttons, priority-encodes them and holds a stable code.
- Emits a one-cycle change strobe whenever the committed code changes.

Parameters:
- DEBOUNCE_CYCLES, 1000000: number of consecutive cycles an encoded value must stay stable before commit (10 ms at 100 MHz); legal range >= 2.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- btn  input  9  raw asynchronous buttons, active-high; btn[0] has highest priority
- noteKey  output  4  committed note code, registered
- note_valid  output  1  1 while a note is committed (noteKey != 7), registered
- key_change  output  1  one-cycle pulse when noteKey or note_valid changes, registered

Behaviour:
- Reset (async, rst_n=0): state=IDLE, noteKey=4'd7, note_valid=0, key_change=0, counter=0, candidate=7, synchroniser flops=0.
- Synchroniser: two flops per button bit before any other logic.
- Combinational priority encode of the synchronised buttons (enc), lowest index wins:
  - btn[0..6] -> codes 0..6
  - btn[7] -> 8
  - btn[8] -> 9
  - no button -> 7 (display all-off / silence)
- Codes 10..15 are never produced.
- State machine states: IDLE, PRESS_DB, HELD, RELEASE_DB.
- IDLE:
  - noteKey=7, note_valid=0.
  - enc!=7 -> PRESS_DB, candidate=enc, cnt=0.
- PRESS_DB:
  - enc==7 -> IDLE, no strobe.
  - enc!=candidate and enc!=7 -> stay, candidate=enc, cnt=0.
  - enc==candidate and cnt==DEBOUNCE_CYCLES-1 -> HELD, noteKey=candidate, note_valid=1, key_change=1 for that one registered cycle.
  - Otherwise cnt+1.
- HELD:
  - enc==noteKey -> stay.
  - enc!=noteKey -> RELEASE_DB, candidate=enc, cnt=0.
- RELEASE_DB:
  - enc==noteKey -> HELD, no strobe (glitch rejected).
  - enc!=candidate -> candidate=enc, cnt=0.
  - cnt==DEBOUNCE_CYCLES-1 with candidate==7 -> IDLE, noteKey=7, note_valid=0, key_change=1.
  - cnt==DEBOUNCE_CYCLES-1 with candidate!=7 -> HELD, noteKey=candidate, key_change=1 (direct note-to-note change, note_valid stays 1).
- Latency: a clean pin change reaches noteKey/key_change exactly DEBOUNCE_CYCLES+3 rising edges later: 2 synchroniser edges, 1 state entry edge, DEBOUNCE_CYCLES-1 counting edges, 1 output register edge.
- key_change is never asserted on two consecutive cycles. It is deasserted on the cycle after any strobe.
- Counter never exceeds DEBOUNCE_CYCLES-1. It is cleared on every candidate change.
- Simultaneous presses resolve by priority. Releasing the higher-priority button while a lower one stays pressed debounces to the lower button's code, with no intermediate 7.
- Reset asserted mid-debounce or mid-hold returns immediately to reset values. The first post-reset commit requires a full debounce period.

Optional Feature:
- Macro: NOTE_KEY_HOLD_LAST_EN.
- Defined: the RELEASE_DB-to-IDLE transition keeps noteKey at the last committed note. note_valid drops to 0 and key_change pulses. IDLE leaves noteKey unchanged, so the display shows the last note played.
- Undefined: behaviour exactly as above (noteKey=7 in IDLE).
- Reset value is 7 in both builds.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset release, btn=0 -> noteKey=7, note_valid=0, key_change=0 held indefinitely.
- Clean press btn=9'h004 at edge 0 -> noteKey=2, note_valid=1 and a single key_change pulse at edge 7. Release -> noteKey=7, note_valid=0, pulse 7 edges after release.
- Bounce: btn[5] toggles every 2 cycles for 20 cycles then holds 1 -> no key_change during bounce. noteKey=5 exactly 7 edges after the final stable transition.
- Priority: btn=9'h180 (bits 7 and 8) -> noteKey=8. Drop bit 7 while holding bit 8 -> noteKey=9 with one pulse, note_valid never deasserts, no intermediate code 7.
- Glitch in HELD: holding btn[0] (noteKey=0), a 2-cycle drop to 0 -> state returns to HELD, noteKey stays 0, no key_change.
- rst_n pulsed low during PRESS_DB at cnt=2 -> outputs immediately 7/0/0. With btn still held after reset release, commit occurs a full 7 edges later. With NOTE_KEY_HOLD_LAST_EN defined, releasing btn[3] gives noteKey=3, note_valid=0, one pulse.

Source files
------------

// File: rtl/note_key_encoder.sv
// Front-panel note button encoder: synchronise, priority-encode, debounce and commit a 4-bit note code.
// Optional build macro NOTE_KEY_HOLD_LAST_EN: on release, keep the last committed note on noteKey.
module note_key_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] btn,
    output logic [3:0] noteKey,
    output logic       note_valid,
    output logic       key_change
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [3:0]       NO_NOTE = 4'd7;
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [8:0]       r_sync1, r_sync2;
    logic [3:0]       r_cand, w_cand_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_note_key, w_key_nxt;
    logic             r_note_valid, w_valid_nxt;
    logic             r_key_change, w_chg_nxt;
    logic             w_commit;
    logic [3:0]       w_enc;

    // Lowest index wins; code 7 is reserved for "no button", so bits 7/8 map to 8/9.
    always_comb begin
        w_enc = NO_NOTE;
        for (int i = 8; i >= 0; i--) begin
            if (r_sync2[i]) w_enc = (i < 7) ? 4'(i) : 4'(i + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_cand       <= NO_NOTE;
            r_cnt        <= '0;
            r_note_key   <= NO_NOTE;
            r_note_valid <= 1'b0;
            r_key_change <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sync1      <= btn;
            r_sync2      <= r_sync1;
            r_cand       <= w_cand_nxt;
            r_cnt        <= w_cnt_nxt;
            r_note_key   <= w_key_nxt;
            r_note_valid <= w_valid_nxt;
            r_key_change <= w_chg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_enc != NO_NOTE) begin
                    w_state_nxt = PRESS_DB;
                    w_cand_nxt  = w_enc;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (w_enc == NO_NOTE) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_enc != r_cand) begin
                    w_cand_nxt = w_enc;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == CNT_TC) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (w_enc != r_note_key) begin
                    w_state_nxt = RELEASE_DB;
                    w_cand_nxt  = w_enc;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_DB: begin
                if (w_enc == r_note_key) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (w_enc != r_cand) begin
                    w_cand_nxt = w_enc;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == CNT_TC) begin
                    w_state_nxt = (r_cand == NO_NOTE) ? IDLE : HELD;
                    w_cnt_nxt   = '0;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_key_nxt   = r_note_key;
        w_valid_nxt = r_note_valid;
        w_chg_nxt   = 1'b0;
        if (w_commit) begin
            w_chg_nxt = 1'b1;
            if (w_state_nxt == HELD) begin
                w_key_nxt   = r_cand;
                w_valid_nxt = 1'b1;
            end else begin
`ifdef NOTE_KEY_HOLD_LAST_EN
                w_key_nxt   = r_note_key;
`else
                w_key_nxt   = NO_NOTE;
`endif
                w_valid_nxt = 1'b0;
            end
        end
    end

    assign noteKey    = r_note_key;
    assign note_valid = r_note_valid;
    assign key_change = r_key_change;

endmodule

// File: tb/tb_note_key_encoder.sv
// Directed bench for note_key_encoder with DEBOUNCE_CYCLES=4 (commit 7 edges after a pin change).
module tb_note_key_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [8:0] btn = '0;
    logic [3:0] noteKey;
    logic       note_valid;
    logic       key_change;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int consec  = 0;
    logic prev_chg = 1'b0;

    note_key_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .noteKey    (noteKey),
        .note_valid (note_valid),
        .key_change (key_change)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_change) pulses++;
        if (key_change && prev_chg) consec++;
        prev_chg = key_change;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Apply a pin change, confirm nothing moves for 6 edges, then the commit on edge 7.
    task automatic change_and_commit(input string tag, input logic [8:0] b,
                                     input int old_key, input int exp_key, input int exp_valid);
        int p0;
        btn = b;
        p0 = pulses;
        tick(6);
        chk({tag, "_early_key"}, noteKey, old_key);
        chk({tag, "_early_pulse"}, pulses - p0, 0);
        tick(1);
        chk({tag, "_key"}, noteKey, exp_key);
        chk({tag, "_valid"}, note_valid, exp_valid);
        chk({tag, "_chg"}, key_change, 1);
        tick(1);
        chk({tag, "_chg_off"}, key_change, 0);
    endtask

    int rel_key;
    int p0;
    logic seen_gap;

    initial begin
`ifdef NOTE_KEY_HOLD_LAST_EN
        rel_key = 3;
`else
        rel_key = 7;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("rst_key", noteKey, 7);
        chk("rst_valid", note_valid, 0);
        chk("rst_chg", key_change, 0);
        #10 rst_n = 1'b1;
        tick(12);
        chk("idle_key", noteKey, 7);
        chk("idle_valid", note_valid, 0);
        chk("idle_pulses", pulses, 0);

        // Clean press and release of btn[2]
        change_and_commit("press2", 9'h004, 7, 2, 1);
        tick(3);
        change_and_commit("rel2", 9'h000, 2, 7, 0);
        tick(3);

        // Bounce on btn[5]: 2 on / 2 off for 20 cycles, then steady
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            btn = 9'h020; tick(2);
            btn = 9'h000; tick(2);
        end
        tick(4);
        chk("bounce_pulses", pulses - p0, 0);
        chk("bounce_key", noteKey, 7);
        change_and_commit("bounce5", 9'h020, 7, 5, 1);
        tick(2);
        change_and_commit("rel5", 9'h000, 5, 7, 0);
        tick(3);

        // Priority: bits 7+8 give 8, dropping bit 7 moves straight to 9
        change_and_commit("prio8", 9'h180, 7, 8, 1);
        tick(2);
        btn = 9'h100;
        p0 = pulses;
        seen_gap = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (noteKey == 4'd7 || !note_valid) seen_gap = 1'b1;
        end
        tick(1);
        chk("prio9_key", noteKey, 9);
        chk("prio9_valid", note_valid, 1);
        chk("prio9_gap", seen_gap, 0);
        tick(3);
        chk("prio9_pulses", pulses - p0, 1);
        change_and_commit("rel9", 9'h000, 9, 7, 0);
        tick(3);

        // Two-cycle drop while holding btn[0] is rejected
        change_and_commit("hold0", 9'h001, 7, 0, 1);
        tick(2);
        p0 = pulses;
        btn = 9'h000; tick(2);
        btn = 9'h001; tick(12);
        chk("glitch_key", noteKey, 0);
        chk("glitch_valid", note_valid, 1);
        chk("glitch_pulses", pulses - p0, 0);

        // Reset mid-hold
        #1 rst_n = 1'b0;
        #1;
        chk("rsthold_key", noteKey, 7);
        chk("rsthold_valid", note_valid, 0);
        chk("rsthold_chg", key_change, 0);
        btn = 9'h000;
        #1 rst_n = 1'b1;
        tick(5);

        // Reset during PRESS_DB at cnt=2, then full re-debounce with btn[3] still held
        btn = 9'h008;
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("rstdb_key", noteKey, 7);
        chk("rstdb_valid", note_valid, 0);
        chk("rstdb_chg", key_change, 0);
        #1 rst_n = 1'b1;
        p0 = pulses;
        tick(6);
        chk("post_rst_early", noteKey, 7);
        chk("post_rst_early_pulse", pulses - p0, 0);
        tick(1);
        chk("post_rst_key", noteKey, 3);
        chk("post_rst_valid", note_valid, 1);
        chk("post_rst_chg", key_change, 1);
        tick(3);
        change_and_commit("rel3", 9'h000, 3, rel_key, 0);
        tick(4);
        chk("idle_after_rel3", noteKey, rel_key);

        chk("kc_consec", consec, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
